// File: rtl/riscoffee_csr_ctrl_if.sv
// Instruction, response, trap and CSR-file signal bundle for riscoffee_csr_ctrl.
// The master side issues requests and models the CSR file; the slave side is the controller.
interface riscoffee_csr_ctrl_if;
  logic        INST_VALID;
  logic        INST_READY;
  logic [2:0]  INST_FUNCT3;
  logic [11:0] INST_CSR;
  logic [31:0] INST_RS1;
  logic [4:0]  INST_SRC;
  logic        RSP_VALID;
  logic [31:0] RSP_DATA;
  logic        RSP_ILLEGAL;
  logic        TRAP_VALID;
  logic        TRAP_READY;
  logic [31:0] TRAP_PC;
  logic [31:0] TRAP_CAUSE;
  logic [31:0] TRAP_TVAL;
  logic        TRAP_DONE;
  logic [31:0] TRAP_TARGET;
  logic        CSR_WRITE;
  logic        CSR_SET;
  logic        CSR_CLEAR;
  logic [11:0] CSR_ADDR;
  logic [31:0] CSR_WDATA;
  logic [31:0] CSR_RDATA;

  modport master (
    output INST_VALID, INST_FUNCT3, INST_CSR, INST_RS1, INST_SRC,
    output TRAP_VALID, TRAP_PC, TRAP_CAUSE, TRAP_TVAL, CSR_RDATA,
    input  INST_READY, RSP_VALID, RSP_DATA, RSP_ILLEGAL,
    input  TRAP_READY, TRAP_DONE, TRAP_TARGET,
    input  CSR_WRITE, CSR_SET, CSR_CLEAR, CSR_ADDR, CSR_WDATA
  );

  modport slave (
    input  INST_VALID, INST_FUNCT3, INST_CSR, INST_RS1, INST_SRC,
    input  TRAP_VALID, TRAP_PC, TRAP_CAUSE, TRAP_TVAL, CSR_RDATA,
    output INST_READY, RSP_VALID, RSP_DATA, RSP_ILLEGAL,
    output TRAP_READY, TRAP_DONE, TRAP_TARGET,
    output CSR_WRITE, CSR_SET, CSR_CLEAR, CSR_ADDR, CSR_WDATA
  );
endinterface

// File: rtl/riscoffee_csr_ctrl.sv
// CSR instruction sequencer and trap entry engine in front of a registered-read CSR file.
// Instructions take ISSUE+CAPT; traps write MEPC/MCAUSE/MTVAL, then read MTVEC for the target.
module riscoffee_csr_ctrl #(
  parameter logic [11:0] MTVEC_ADDR  = 12'h305,
  parameter logic [11:0] MEPC_ADDR   = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR = 12'h342,
  parameter logic [11:0] MTVAL_ADDR  = 12'h343
) (
  input logic                 CLK,
  input logic                 RST_N,
  riscoffee_csr_ctrl_if.slave bus_io
);

  typedef enum logic [2:0] {
    StIdle, StIssue, StCapt, StTEpc, StTCause, StTTval, StTVec, StTCapt
  } state_e;

  state_e      state_q, state_d;
  logic        csr_write_q, csr_write_d;
  logic        csr_set_q, csr_set_d;
  logic        csr_clear_q, csr_clear_d;
  logic [11:0] csr_addr_q, csr_addr_d;
  logic [31:0] csr_wdata_q, csr_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_illegal_q, rsp_illegal_d;
  logic        trap_done_q, trap_done_d;
  logic [31:0] trap_target_q, trap_target_d;
  logic        illegal_q, illegal_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] tval_q, tval_d;

  logic        trap_ready, inst_ready, trap_accept, inst_accept;
  logic [31:0] operand;
  logic        eff_write, inst_illegal;
  logic [31:0] vec_base, vec_target;
  logic        unused_pc;

  assign trap_ready  = RST_N && (state_q == StIdle);
  assign inst_ready  = trap_ready && !bus_io.TRAP_VALID;
  assign trap_accept = trap_ready && bus_io.TRAP_VALID;
  assign inst_accept = inst_ready && bus_io.INST_VALID;

  assign operand   = bus_io.INST_FUNCT3[2] ? {27'd0, bus_io.INST_SRC} : bus_io.INST_RS1;
  // Set/clear with a zero source is a pure read and never counts as a write.
  assign eff_write = (bus_io.INST_FUNCT3[1:0] == 2'b01) ||
                     (bus_io.INST_FUNCT3[1] && (bus_io.INST_SRC != 5'd0));
  assign inst_illegal = (bus_io.INST_FUNCT3[1:0] == 2'b00) ||
                        (eff_write && (bus_io.INST_CSR[11:10] == 2'b11));

  assign vec_base   = {bus_io.CSR_RDATA[31:2], 2'b00};
  assign vec_target = ((bus_io.CSR_RDATA[1:0] == 2'b01) && cause_q[31]) ?
                      vec_base + {cause_q[29:0], 2'b00} : vec_base;
  assign unused_pc  = ^bus_io.TRAP_PC[1:0];

  always_comb begin
    state_d       = state_q;
    csr_write_d   = 1'b0;
    csr_set_d     = 1'b0;
    csr_clear_d   = 1'b0;
    csr_addr_d    = csr_addr_q;
    csr_wdata_d   = csr_wdata_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_illegal_d = rsp_illegal_q;
    trap_done_d   = 1'b0;
    trap_target_d = trap_target_q;
    illegal_d     = illegal_q;
    cause_d       = cause_q;
    tval_d        = tval_q;
    case (state_q)
      StIdle: begin
        if (trap_accept) begin
          csr_addr_d  = MEPC_ADDR;
          csr_wdata_d = {bus_io.TRAP_PC[31:2], 2'b00};
          csr_write_d = 1'b1;
          cause_d     = bus_io.TRAP_CAUSE;
          tval_d      = bus_io.TRAP_TVAL;
          state_d     = StTEpc;
        end else if (inst_accept) begin
          csr_addr_d  = bus_io.INST_CSR;
          csr_wdata_d = operand;
          illegal_d   = inst_illegal;
          csr_write_d = !inst_illegal && eff_write && (bus_io.INST_FUNCT3[1:0] == 2'b01);
          csr_set_d   = !inst_illegal && eff_write && (bus_io.INST_FUNCT3[1:0] == 2'b10);
          csr_clear_d = !inst_illegal && eff_write && (bus_io.INST_FUNCT3[1:0] == 2'b11);
          state_d     = StIssue;
        end
      end
      StIssue: state_d = StCapt;
      StCapt: begin
        rsp_valid_d   = 1'b1;
        rsp_data_d    = illegal_q ? 32'd0 : bus_io.CSR_RDATA;
        rsp_illegal_d = illegal_q;
        state_d       = StIdle;
      end
      StTEpc: begin
        csr_addr_d  = MCAUSE_ADDR;
        csr_wdata_d = cause_q;
        csr_write_d = 1'b1;
        state_d     = StTCause;
      end
      StTCause: begin
        csr_addr_d  = MTVAL_ADDR;
        csr_wdata_d = tval_q;
        csr_write_d = 1'b1;
        state_d     = StTTval;
      end
      StTTval: begin
        csr_addr_d = MTVEC_ADDR;
        state_d    = StTVec;
      end
      StTVec: state_d = StTCapt;
      StTCapt: begin
        trap_target_d = vec_target;
        trap_done_d   = 1'b1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= StIdle;
      csr_write_q   <= 1'b0;
      csr_set_q     <= 1'b0;
      csr_clear_q   <= 1'b0;
      csr_addr_q    <= '0;
      csr_wdata_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_illegal_q <= 1'b0;
      trap_done_q   <= 1'b0;
      trap_target_q <= '0;
      illegal_q     <= 1'b0;
      cause_q       <= '0;
      tval_q        <= '0;
    end else begin
      state_q       <= state_d;
      csr_write_q   <= csr_write_d;
      csr_set_q     <= csr_set_d;
      csr_clear_q   <= csr_clear_d;
      csr_addr_q    <= csr_addr_d;
      csr_wdata_q   <= csr_wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_illegal_q <= rsp_illegal_d;
      trap_done_q   <= trap_done_d;
      trap_target_q <= trap_target_d;
      illegal_q     <= illegal_d;
      cause_q       <= cause_d;
      tval_q        <= tval_d;
    end
  end

  assign bus_io.TRAP_READY  = trap_ready;
  assign bus_io.INST_READY  = inst_ready;
  assign bus_io.RSP_VALID   = rsp_valid_q;
  assign bus_io.RSP_DATA    = rsp_data_q;
  assign bus_io.RSP_ILLEGAL = rsp_illegal_q;
  assign bus_io.TRAP_DONE   = trap_done_q;
  assign bus_io.TRAP_TARGET = trap_target_q;
  assign bus_io.CSR_WRITE   = csr_write_q;
  assign bus_io.CSR_SET     = csr_set_q;
  assign bus_io.CSR_CLEAR   = csr_clear_q;
  assign bus_io.CSR_ADDR    = csr_addr_q;
  assign bus_io.CSR_WDATA   = csr_wdata_q;

endmodule

// File: doc/riscoffee_csr_ctrl.md
RISCOFFEE_CSR_CTRL -- requirements
Module: riscoffee_csr_ctrl

Interface
REQ-001 SHALL have parameter MTVEC_ADDR, default 12'h305, meaning trap-vector CSR address.
REQ-002 SHALL have parameter MEPC_ADDR, default 12'h341, meaning exception-PC CSR address.
REQ-003 SHALL have parameter MCAUSE_ADDR, default 12'h342, meaning trap-cause CSR address.
REQ-004 SHALL have parameter MTVAL_ADDR, default 12'h343, meaning trap-value CSR address.
REQ-005 SHALL have port CLK  in  1  clock; all logic on posedge.
REQ-006 SHALL have port RST_N  in  1  reset, synchronous, active-low.
REQ-007 SHALL have ports INST_VALID in 1, INST_READY out 1, INST_FUNCT3 in 3, INST_CSR in 12, INST_RS1 in 32 (rs1 value), INST_SRC in 5 (rs1 index or zimm).
REQ-008 SHALL have ports RSP_VALID out 1, RSP_DATA out 32 (old CSR value), RSP_ILLEGAL out 1.
REQ-009 SHALL have ports TRAP_VALID in 1, TRAP_READY out 1, TRAP_PC in 32, TRAP_CAUSE in 32, TRAP_TVAL in 32, TRAP_DONE out 1, TRAP_TARGET out 32.
REQ-010 SHALL have CSR-file ports CSR_WRITE, CSR_SET, CSR_CLEAR out 1 each, CSR_ADDR out 12, CSR_WDATA out 32, CSR_RDATA in 32 (registered read, valid the cycle after the address, pre-write value).

Function
REQ-011 SHALL implement states IDLE, ISSUE, CAPT, T_EPC, T_CAUSE, T_TVAL, T_VEC, T_CAPT.
REQ-012 TRAP_READY SHALL be 1 iff state==IDLE; INST_READY SHALL be 1 iff state==IDLE and TRAP_VALID==0 (trap wins simultaneous requests).
REQ-013 On instruction accept SHALL latch all INST_* fields and go to ISSUE.
REQ-014 Operand SHALL be {27'b0,INST_SRC} when FUNCT3[2]==1, else INST_RS1.
REQ-015 FUNCT3 001/101 SHALL drive CSR_WRITE; 010/110 CSR_SET; 011/111 CSR_CLEAR; exactly one strobe, only in ISSUE.
REQ-016 SET/CLEAR forms with INST_SRC==0 SHALL drive no strobe (read only).
REQ-017 FUNCT3 000 or 100, or an effective write to CSR[11:10]==2'b11, SHALL be illegal: no strobe, response with RSP_ILLEGAL=1, RSP_DATA=0.
REQ-018 In ISSUE SHALL drive CSR_ADDR=latched CSR, CSR_WDATA=operand, then go to CAPT.
REQ-019 In CAPT SHALL register RSP_DATA<=CSR_RDATA, RSP_VALID<=1, go to IDLE; response visible 3 cycles after accept edge.
REQ-020 RSP_VALID and TRAP_DONE SHALL be single-cycle pulses with no backpressure; a new request MAY be accepted in the pulse cycle.
REQ-021 Trap accept SHALL latch PC/CAUSE/TVAL, then one state per cycle: T_EPC writes MEPC={PC[31:2],2'b00}; T_CAUSE writes MCAUSE; T_TVAL writes MTVAL; T_VEC reads MTVEC with no strobe; T_CAPT computes target.
REQ-022 Target: base={mtvec[31:2],2'b00}; if mtvec[1:0]==01 and CAUSE[31]==1, base+{CAUSE[29:0],2'b00} mod 2^32, else base.
REQ-023 T_CAPT SHALL register TRAP_TARGET and pulse TRAP_DONE, go to IDLE; TRAP_DONE visible 6 cycles after accept edge.
REQ-024 Outside ISSUE/T_EPC/T_CAUSE/T_TVAL all strobes SHALL be 0; CSR_ADDR, CSR_WDATA, RSP_DATA, TRAP_TARGET SHALL hold last values.

Reset
REQ-025 RST_N==0 at any state SHALL force IDLE, all outputs 0, discard in-flight request, no response pulse.
REQ-026 First request SHALL be acceptable in the first cycle with RST_N==1.

Verification
REQ-027 CSR 0x340=0x00000F0F, CSRRS 0x340 rs1=0x000000F0 src=5 -> RSP_DATA=0x00000F0F, later read 0x00000FFF.
REQ-028 CSRRCI 0x340 src=0 -> no strobe, RSP_DATA=old value, CSR unchanged.
REQ-029 CSRRW 0xC00, or FUNCT3=100 -> RSP_ILLEGAL=1, RSP_DATA=0, no strobe.
REQ-030 TRAP and INST same cycle, mtvec=0x80000101, CAUSE=0x80000007, PC=0x1003 -> trap first, MEPC=0x1000, TRAP_TARGET=0x8000011C; INST accepted afterward.
REQ-031 RST_N low during T_TVAL -> IDLE next cycle, TRAP_DONE never pulses, all CSRs 0.
